// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and a future receiver.
//   tx_state_t                    transmitter frame state
//   UART_DEFAULT_CLOCKS_PER_BAUD  50 MHz / 115200 baud
//   PARITY_SEL_EVEN / _ODD        parity-select values
//   parity_of()                   parity of a word (up to 9 bits) for a given select
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int unsigned UART_DEFAULT_CLOCKS_PER_BAUD = 434;

    localparam logic PARITY_SEL_EVEN = 1'b0;
    localparam logic PARITY_SEL_ODD  = 1'b1;

    // Zero-extended upper bits do not change the XOR.
    function automatic logic parity_of(input logic [8:0] word, input logic odd_sel);
        return (^word) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with first-word fall-through read.
//   clk    system clock, posedge
//   reset  synchronous active-high, empties the FIFO
//   push   store wdata; ignored while full
//   wdata  word to store
//   pop    discard head word; ignored while empty
//   rdata  head word (valid while empty=0)
//   full   DEPTH words held
//   empty  no words held
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO. Frame = start bit (0),
// DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
// Queued words go out back-to-back with no idle gap between frames.
//   clk    system clock, posedge
//   reset  synchronous active-high; aborts any frame, empties the FIFO
//   write  push data into the FIFO; dropped while full
//   data   word to transmit
//   full   FIFO holds FIFO_DEPTH words
//   busy   FIFO non-empty or a frame in progress
//   tx     serial line, idles high
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data
// bits; parameter PARITY_ODD (0 even, 1 odd) then selects the sense.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = UART_DEFAULT_CLOCKS_PER_BAUD,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 4
`ifdef UART_TX_PARITY_EN
    ,
    parameter logic        PARITY_ODD      = PARITY_SEL_EVEN
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] data,
    output logic                 full,
    output logic                 busy,
    output logic                 tx
);

    localparam int unsigned BW = $clog2(CLOCKS_PER_BAUD);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    tx_state_t            state;
    logic [BW-1:0]        baud_cnt;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 baud_tc;
    logic                 frame_done;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (write),
        .wdata (data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_tc    = (baud_cnt == BAUD_LAST);
    assign frame_done = (state == ST_STOP) && baud_tc && (bit_cnt == STOP_LAST);
    // A word is loaded either from idle or straight out of the last stop bit,
    // so back-to-back frames need no IDLE cycle in between.
    assign fifo_pop   = !fifo_empty && ((state == ST_IDLE) || frame_done);

    assign full = fifo_full;
    assign busy = !fifo_empty || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (fifo_pop) begin
            state      <= ST_START;
            tx         <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            // Captured at load time because the shift register is consumed.
            parity_bit <= parity_of(9'(fifo_rdata), PARITY_ODD);
`endif
        end else if (state == ST_IDLE) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!baud_tc) begin
            baud_cnt <= baud_cnt + BW'(1);
        end else begin
            baud_cnt <= '0;
            case (state)
                ST_START: begin
                    state   <= ST_DATA;
                    tx      <= shift_reg[0];
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        state   <= ST_PARITY;
                        tx      <= parity_bit;
`else
                        state   <= ST_STOP;
                        tx      <= 1'b1;
`endif
                    end else begin
                        bit_cnt   <= bit_cnt + CW'(1);
                        shift_reg <= shift_reg >> 1;
                        tx        <= shift_reg[1];
                    end
                end
                ST_PARITY: begin
                    state   <= ST_STOP;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end
                ST_STOP: begin
                    // End of frame with a non-empty FIFO is taken by fifo_pop.
                    if (bit_cnt == STOP_LAST) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    tx <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo with CLOCKS_PER_BAUD=4.
// A queue-based line model predicts tx/busy/full every cycle; an independent
// line decoder recovers transmitted words; literal frames pin the model.
// Honours UART_TX_PARITY_EN when the build defines it.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB    = 1;
`else
    localparam int PB    = 0;
`endif
    localparam int FB    = 1 + DB + PB + SB;
    localparam bit TB_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [7:0] data;
    logic       full, busy, tx;
    logic       write7;
    logic [6:0] data7;
    logic       full7, busy7, tx7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLOCKS_PER_BAUD (C),
        .DATA_BITS       (DB),
        .STOP_BITS       (SB),
        .FIFO_DEPTH      (DEPTH)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD    (TB_ODD)
`endif
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .data  (data),
        .full  (full),
        .busy  (busy),
        .tx    (tx)
    );

    uart_tx_fifo #(
        .CLOCKS_PER_BAUD (C),
        .DATA_BITS       (7),
        .STOP_BITS       (2),
        .FIFO_DEPTH      (DEPTH)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD    (TB_ODD)
`endif
    ) u_dut7 (
        .clk   (clk),
        .reset (reset),
        .write (write7),
        .data  (data7),
        .full  (full7),
        .busy  (busy7),
        .tx    (tx7)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_cyc = 0;
    logic [15:0] m_frame = '1;
    bit          m_eof;
    bit          m_push;

    function automatic logic [15:0] build_frame(input logic [7:0] w);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = w[i];
        if (PB == 1) f[1+DB] = (^w) ^ TB_ODD;
        return f;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_cyc    = 0;
        end else begin
            m_eof  = m_active && (m_cyc == FB*C - 1);
            m_push = write && (m_q.size() < DEPTH);
            if ((!m_active || m_eof) && m_q.size() > 0) begin
                m_frame  = build_frame(m_q.pop_front());
                m_active = 1'b1;
                m_cyc    = 0;
            end else if (m_eof) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_cyc++;
            end
            if (m_push) m_q.push_back(data);
        end
    end

    always @(negedge clk) begin
        chk("model_tx",   tx,   m_active ? m_frame[m_cyc/C] : 1'b1);
        chk("model_busy", busy, (m_q.size() > 0) || m_active);
        chk("model_full", full, m_q.size() == DEPTH);
    end

    // ---------------- line decoder ----------------
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_word = '0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_word = '0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= C && rx_cnt < C*(1+DB) && (rx_cnt % C) == C/2)
                rx_word[rx_cnt/C - 1] = tx;
            if (rx_cnt == C*(1+DB+PB) + C/2) begin
                rx_q.push_back(rx_word);
                rx_busy = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name, input int max, output int n);
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx_busy = 1'b0;
        rx_q.delete();
    endtask

    // Writes one word into an idle DUT and compares every cycle of the
    // frame with a literal bit vector (bit 0 = start bit).
    task automatic send_and_check(input string name, input bit use7, input logic [7:0] word,
                                  input logic [15:0] bits, input int nbits);
        if (use7) begin write7 = 1'b1; data7 = word[6:0]; end
        else      begin write  = 1'b1; data  = word;      end
        @(negedge clk);
        write  = 1'b0;
        write7 = 1'b0;
        chk({name, "_tx_after_write"}, use7 ? tx7 : tx, 1'b1);
        chk({name, "_busy_after_write"}, use7 ? busy7 : busy, 1'b1);
        @(negedge clk);
        for (int k = 0; k < nbits*C; k++) begin
            chk($sformatf("%s_cycle%0d", name, k), use7 ? tx7 : tx, bits[k/C]);
            @(negedge clk);
        end
        chk({name, "_busy_end"}, use7 ? busy7 : busy, 1'b0);
        chk({name, "_tx_end"}, use7 ? tx7 : tx, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset  = 1'b1;
        write  = 1'b0;
        data   = '0;
        write7 = 1'b0;
        data7  = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx",   tx,   1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_full", full, 1'b0);
        chk("reset_tx7",  tx7,  1'b1);
        reset = 1'b0;
        @(negedge clk);

        // 1: single A5 frame, literal waveform
`ifdef UART_TX_PARITY_EN
        send_and_check("a5", 1'b0, 8'hA5, {1'b1, 1'b0 ^ TB_ODD, 8'hA5, 1'b0}, 11);
`else
        send_and_check("a5", 1'b0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10);
`endif

        // 6: parity of 07 (three ones)
`ifdef UART_TX_PARITY_EN
        send_and_check("p07", 1'b0, 8'h07, {1'b1, 1'b1 ^ TB_ODD, 8'h07, 1'b0}, 11);
`else
        send_and_check("p07", 1'b0, 8'h07, {1'b1, 8'h07, 1'b0}, 10);
`endif

        // 2: three back-to-back frames
        rx_q.delete();
        write = 1'b1; data = 8'h01;
        @(negedge clk); data = 8'h02;
        @(negedge clk); data = 8'h03;
        @(negedge clk); write = 1'b0;
        wait_idle("b2b", 400, n);
        chk("b2b_len", n, 3*FB*C - 1);
        chk("b2b_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            chk($sformatf("b2b_word%0d", i), rx_q[i], i + 1);

        // 3: overfill during a frame
        @(negedge clk);
        rx_q.delete();
        write = 1'b1; data = 8'h10;
        @(negedge clk); write = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            write = 1'b1; data = 8'(8'h11 + i);
            @(negedge clk);
            if (i == 3) chk("fill_full", full, 1'b1);
        end
        write = 1'b0;
        wait_idle("fill", 600, n);
        chk("fill_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("fill_word%0d", i), rx_q[i], 8'h10 + i);

        // 4: reset mid-data
        @(negedge clk);
        write = 1'b1; data = 8'hFF;
        @(negedge clk); write = 1'b0;
        repeat (1 + 3*C) @(negedge clk);
        chk("mid_tx_busy", busy, 1'b1);
        do_reset();
        chk("rst_tx",   tx,   1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
`ifdef UART_TX_PARITY_EN
        send_and_check("after_rst", 1'b0, 8'h3C, {1'b1, 1'b0 ^ TB_ODD, 8'h3C, 1'b0}, 11);
`else
        send_and_check("after_rst", 1'b0, 8'h3C, {1'b1, 8'h3C, 1'b0}, 10);
`endif

        // 5: 7 data bits, 2 stop bits
`ifdef UART_TX_PARITY_EN
        send_and_check("w7", 1'b1, 8'h55, {2'b11, 1'b0 ^ TB_ODD, 7'h55, 1'b0}, 11);
`else
        send_and_check("w7", 1'b1, 8'h55, {2'b11, 7'h55, 1'b0}, 10);
`endif

        // randomized traffic, one reset in the middle
        for (int i = 0; i < 1500; i++) begin
            reset = (i == 700);
            write = (i != 700) && ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
            @(negedge clk);
            if (i == 700) begin
                rx_busy = 1'b0;
                rx_q.delete();
            end
        end
        reset = 1'b0;
        write = 1'b0;
        wait_idle("rand_drain", 6*FB*C, n);
        chk("final_busy", busy, 1'b0);
        chk("final_tx",   tx,   1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
